// File: rtl/debug_host_pkg.sv
// debug_host_pkg: opcodes, halt word, command and state encodings shared by the debug host
package debug_host_pkg;
    localparam logic [7:0] OP_LOAD = 8'h04;
    localparam logic [7:0] OP_STEP = 8'h05;
    localparam logic [7:0] OP_RUN = 8'h03;
    localparam logic [7:0] OP_RESET = 8'h0C;
    localparam logic [31:0] HALT_WORD = 32'h0000003F;

    typedef enum logic [1:0] {
        CMD_LOAD = 2'b00,
        CMD_STEP = 2'b01,
        CMD_RUN = 2'b10,
        CMD_RESET = 2'b11
    } cmd_t;

    typedef enum logic [2:0] {
        IDLE,
        SEND_CMD,
        LOAD_FETCH,
        LOAD_BYTE,
        RX_DUMP,
        RX_TRAIL,
        DONE
    } state_t;

    function automatic logic [7:0] opcode(cmd_t c);
        return c == CMD_LOAD ? OP_LOAD : c == CMD_STEP ? OP_STEP : c == CMD_RUN ? OP_RUN : OP_RESET;
    endfunction
endpackage

// File: rtl/debug_word_assembler.sv
// debug_word_assembler: packs received bytes MSB first into words and strobes each completed word
module debug_word_assembler #(
    parameter int NB = 8,
    parameter int NB_DATA = 32
) (
    input logic i_clk,
    input logic i_reset,
    input logic clear,
    input logic push,
    input logic [NB-1:0] data,
    output logic last,
    output logic word_valid,
    output logic [NB_DATA-1:0] word
);
    logic [1:0] cnt;
    logic [NB_DATA-1:0] sh;

    assign last = push && cnt == 2'd3;

    // shift bytes in, publish the word and its one-cycle strobe on the fourth byte
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cnt <= '0;
            sh <= '0;
            word_valid <= 1'b0;
            word <= '0;
        end else begin
            word_valid <= last;
            if (last) word <= {sh[NB_DATA-NB-1:0], data};
            if (clear) begin
                cnt <= '0;
                sh <= '0;
            end else if (push) begin
                cnt <= cnt + 2'd1;
                sh <= {sh[NB_DATA-NB-1:0], data};
            end
        end
    end
endmodule

// File: rtl/debug_host.sv
// debug_host: UART debug host that loads programs, issues step/run/reset and collects state dumps
module debug_host
    import debug_host_pkg::*;
#(
    parameter int NB = 8,
    parameter int NB_DATA = 32,
    parameter int N_REG_WORDS = 32,
    parameter int N_MEM_WORDS = 129,
    parameter int NB_PADDR = 8,
    parameter int TIMEOUT = 1048576
) (
    input logic i_clk,
    input logic i_reset,
    input logic i_cmd_valid,
    input logic [1:0] i_cmd,
    output logic o_cmd_ready,
    output logic [NB_PADDR-1:0] o_prog_addr,
    input logic [NB_DATA-1:0] i_prog_data,
    input logic i_rx_empty,
    input logic [NB-1:0] i_rx_data,
    output logic o_rd_uart,
    input logic i_tx_full,
    output logic o_wr_uart,
    output logic [NB-1:0] o_tx_data,
    output logic o_word_valid,
    output logic [NB_DATA-1:0] o_word,
    output logic o_word_is_mem,
    output logic [7:0] o_word_idx,
    output logic o_dump_done,
    output logic o_error,
    output logic o_busy
);
    localparam int IW = TIMEOUT > 2 ? $clog2(TIMEOUT) : 1;

    state_t state;
    cmd_t cmd;
    logic [NB_DATA-1:0] load_word;
    logic [1:0] tx_cnt;
    logic fetch_wait;
    logic last_load;
    logic [7:0] idx;
    logic mem;
    logic [IW-1:0] idle;
    logic last_byte;

    assign o_cmd_ready = state == IDLE;
    assign o_busy = state != IDLE;
    assign o_wr_uart = (state == SEND_CMD || state == LOAD_BYTE) && !i_tx_full;
    assign o_tx_data = state == SEND_CMD ? opcode(cmd) : state == LOAD_BYTE ? load_word[NB_DATA-1 -: NB] : '0;
    assign o_rd_uart = (state == RX_DUMP || state == RX_TRAIL) && !i_rx_empty;

    debug_word_assembler #(.NB(NB), .NB_DATA(NB_DATA)) u_asm (
        .i_clk(i_clk),
        .i_reset(i_reset),
        .clear(state != RX_DUMP),
        .push(o_rd_uart && state == RX_DUMP),
        .data(i_rx_data),
        .last(last_byte),
        .word_valid(o_word_valid),
        .word(o_word)
    );

    // command sequencing: opcode push, program streaming, dump collection and idle timeout
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= IDLE;
            cmd <= CMD_LOAD;
            load_word <= '0;
            tx_cnt <= '0;
            fetch_wait <= 1'b0;
            last_load <= 1'b0;
            o_prog_addr <= '0;
            idx <= '0;
            mem <= 1'b0;
            idle <= '0;
            o_word_idx <= '0;
            o_word_is_mem <= 1'b0;
            o_dump_done <= 1'b0;
            o_error <= 1'b0;
        end else begin
            o_dump_done <= 1'b0;
            o_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_cmd_valid) begin
                        cmd <= cmd_t'(i_cmd);
                        state <= SEND_CMD;
                    end
                end
                SEND_CMD: begin
                    idle <= '0;
                    if (!i_tx_full) state <= cmd == CMD_LOAD ? LOAD_FETCH : cmd == CMD_RESET ? RX_TRAIL : RX_DUMP;
                end
                LOAD_FETCH: begin
                    fetch_wait <= !fetch_wait;
                    if (fetch_wait) begin
                        load_word <= i_prog_data;
                        last_load <= i_prog_data == HALT_WORD || &o_prog_addr;
                        tx_cnt <= '0;
                        state <= LOAD_BYTE;
                    end
                end
                LOAD_BYTE: begin
                    if (!i_tx_full) begin
                        load_word <= load_word << NB;
                        tx_cnt <= tx_cnt + 2'd1;
                        if (tx_cnt == 2'd3) begin
                            if (last_load) state <= DONE;
                            else begin
                                o_prog_addr <= o_prog_addr + 1'b1;
                                state <= LOAD_FETCH;
                            end
                        end
                    end
                end
                RX_DUMP, RX_TRAIL: begin
                    if (!i_rx_empty) begin
                        idle <= '0;
                        if (state == RX_TRAIL) state <= DONE;
                        else if (last_byte) begin
                            o_word_idx <= idx;
                            o_word_is_mem <= mem;
                            if (!mem && idx == 8'(N_REG_WORDS - 1)) begin
                                mem <= 1'b1;
                                idx <= '0;
                            end else if (mem && idx == 8'(N_MEM_WORDS - 1)) begin
                                o_dump_done <= 1'b1;
                                state <= cmd == CMD_RUN ? RX_TRAIL : DONE;
                            end else idx <= idx + 8'd1;
                        end
                    end else if (idle == IW'(TIMEOUT - 1)) begin
                        o_error <= 1'b1;
                        state <= IDLE;
                        idx <= '0;
                        mem <= 1'b0;
                        idle <= '0;
                    end else idle <= idle + 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    o_prog_addr <= '0;
                    idx <= '0;
                    mem <= 1'b0;
                    idle <= '0;
                    fetch_wait <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_debug_host.sv
// tb_debug_host: randomized self-checking bench with FIFO/ROM models and a byte-level reference
module tb_debug_host;
    localparam int TO = 64;

    logic i_clk = 1'b0;
    logic i_reset = 1'b1;
    logic i_cmd_valid = 1'b0;
    logic [1:0] i_cmd = 2'b00;
    logic o_cmd_ready;
    logic [7:0] o_prog_addr;
    logic [31:0] i_prog_data = '0;
    logic i_rx_empty = 1'b1;
    logic [7:0] i_rx_data = '0;
    logic o_rd_uart;
    logic i_tx_full = 1'b0;
    logic o_wr_uart;
    logic [7:0] o_tx_data;
    logic o_word_valid;
    logic [31:0] o_word;
    logic o_word_is_mem;
    logic [7:0] o_word_idx;
    logic o_dump_done, o_error, o_busy;

    int total = 0, bad = 0;
    int cyc = 0, last_pop = 0, err_cyc = 0, dones = 0, errs = 0;
    bit stall_en = 0, full_en = 0, force_full = 0;
    logic [7:0] addr_s = '0;
    logic [31:0] rom [256];
    logic [7:0] rx_q[$];
    logic [7:0] tx_log[$];
    logic [7:0] exp_tx[$];
    logic [40:0] words[$];

    always #5 i_clk = ~i_clk;

    debug_host #(.TIMEOUT(TO)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_cmd_valid(i_cmd_valid), .i_cmd(i_cmd),
        .o_cmd_ready(o_cmd_ready), .o_prog_addr(o_prog_addr), .i_prog_data(i_prog_data),
        .i_rx_empty(i_rx_empty), .i_rx_data(i_rx_data), .o_rd_uart(o_rd_uart),
        .i_tx_full(i_tx_full), .o_wr_uart(o_wr_uart), .o_tx_data(o_tx_data),
        .o_word_valid(o_word_valid), .o_word(o_word), .o_word_is_mem(o_word_is_mem),
        .o_word_idx(o_word_idx), .o_dump_done(o_dump_done), .o_error(o_error), .o_busy(o_busy)
    );

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // FIFO, ROM and output monitor: inputs change on the falling edge, DUT handshakes sampled 1 time unit later
    initial begin
        forever begin
            @(posedge i_clk);
            cyc++;
            @(negedge i_clk);
            i_prog_data = rom[addr_s];
            addr_s = o_prog_addr;
            i_tx_full = force_full || (full_en && $urandom_range(3) == 0);
            i_rx_empty = rx_q.size() == 0 || (stall_en && $urandom_range(3) == 0);
            i_rx_data = rx_q.size() != 0 ? rx_q[0] : 8'h00;
            if (o_word_valid) words.push_back({o_word_is_mem, o_word_idx, o_word});
            if (o_dump_done) dones++;
            if (o_error) begin
                errs++;
                err_cyc = cyc;
            end
            #1;
            chk("fifo_guard", {62'd0, o_wr_uart & i_tx_full, o_rd_uart & i_rx_empty}, 64'd0);
            if (o_wr_uart) tx_log.push_back(o_tx_data);
            if (o_rd_uart) begin
                void'(rx_q.pop_front());
                last_pop = cyc + 1;
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    task automatic tick(int n);
        repeat (n) begin
            @(negedge i_clk);
            #2;
        end
    endtask

    task automatic issue(logic [1:0] c);
        tick(1);
        i_cmd = c;
        i_cmd_valid = 1'b1;
        tick(1);
        i_cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(string tag, int limit);
        int n = 0;
        while (!o_cmd_ready && n < limit) begin
            tick(1);
            n++;
        end
        chk({tag, " idle"}, o_cmd_ready, 1);
    endtask

    task automatic chk_quiet(string tag);
        chk({tag, " outs"}, {o_busy, o_rd_uart, o_wr_uart, o_word_valid, o_dump_done, o_error,
                             o_prog_addr, o_word_idx, o_word_is_mem, o_tx_data, o_word}, 64'd0);
        chk({tag, " ready"}, o_cmd_ready, 1);
    endtask

    task automatic run_load(string tag, bit ff);
        exp_tx.delete();
        exp_tx.push_back(8'h04);
        for (int a = 0; a < 256; a++) begin
            for (int j = 3; j >= 0; j--) exp_tx.push_back(rom[a][j*8 +: 8]);
            if (rom[a] == 32'h0000003F) break;
        end
        tx_log.delete();
        issue(2'b00);
        if (ff) begin
            tick(3);
            force_full = 1;
            tick(10);
            force_full = 0;
        end
        wait_idle(tag, 8000);
        chk({tag, " ntx"}, tx_log.size(), exp_tx.size());
        for (int i = 0; i < tx_log.size() && i < exp_tx.size(); i++)
            chk($sformatf("%s tx%0d", tag, i), tx_log[i], exp_tx[i]);
        chk({tag, " addr0"}, o_prog_addr, 0);
    endtask

    task automatic run_dump(logic [1:0] c, bit pattern, string tag);
        logic [7:0] b[$];
        logic [31:0] w;
        for (int k = 0; k < 161; k++) begin
            w = pattern ? 32'(k < 32 ? k : (k - 32) * 4) : $urandom;
            for (int j = 3; j >= 0; j--) b.push_back(w[j*8 +: 8]);
        end
        if (c == 2'b10) b.push_back(8'($urandom));
        words.delete();
        tx_log.delete();
        dones = 0;
        rx_q = b;
        issue(c);
        wait_idle(tag, 6000);
        chk({tag, " ntx"}, tx_log.size(), 1);
        chk({tag, " op"}, tx_log.size() != 0 ? tx_log[0] : 8'h00, c == 2'b01 ? 8'h05 : 8'h03);
        chk({tag, " nwords"}, words.size(), 161);
        chk({tag, " dones"}, dones, 1);
        chk({tag, " rx_left"}, rx_q.size(), 0);
        for (int k = 0; k < words.size() && k < 161; k++)
            chk($sformatf("%s w%0d", tag, k), words[k],
                {k >= 32, 8'(k < 32 ? k : k - 32), b[4*k], b[4*k+1], b[4*k+2], b[4*k+3]});
    endtask

    initial begin
        int n;
        for (int a = 0; a < 256; a++) rom[a] = 32'h0;
        tick(3);
        chk_quiet("reset");
        i_reset = 1'b0;
        tick(2);
        chk_quiet("post_reset");

        rom[0] = 32'h8C010004;
        rom[1] = 32'h0000003F;
        run_load("load_fixed", 0);
        run_load("load_full10", 1);

        full_en = 1;
        for (int a = 0; a < 256; a++) begin
            do rom[a] = $urandom; while (rom[a] == 32'h0000003F);
        end
        rom[$urandom_range(20, 5)] = 32'h0000003F;
        run_load("load_rand", 0);
        for (int a = 0; a < 256; a++) if (rom[a] == 32'h0000003F) rom[a] = 32'h1;
        run_load("load_maxaddr", 0);

        stall_en = 1;
        run_dump(2'b01, 1, "step_pat");
        run_dump(2'b10, 1, "run_pat");
        run_dump(2'b01, 0, "step_rand");
        run_dump(2'b10, 0, "run_rand");

        rx_q = {8'hA5};
        tx_log.delete();
        words.delete();
        issue(2'b11);
        wait_idle("reset_cmd", 500);
        chk("reset_cmd op", tx_log.size() != 0 ? tx_log[0] : 8'h00, 8'h0C);
        chk("reset_cmd rx_left", rx_q.size(), 0);
        chk("reset_cmd nwords", words.size(), 0);

        stall_en = 0;
        rx_q.delete();
        for (int i = 0; i < 102; i++) rx_q.push_back(8'($urandom));
        words.delete();
        errs = 0;
        dones = 0;
        issue(2'b01);
        wait_idle("timeout", 1000);
        chk("timeout errs", errs, 1);
        chk("timeout delay", err_cyc - last_pop, 64);
        chk("timeout nwords", words.size(), 25);
        chk("timeout dones", dones, 0);
        tick(2);
        chk("timeout nwords_after", words.size(), 25);
        run_dump(2'b01, 1, "after_timeout");

        stall_en = 1;
        rx_q.delete();
        for (int k = 0; k < 644; k++) rx_q.push_back(8'($urandom));
        words.delete();
        issue(2'b01);
        n = 0;
        while (words.size() < 40 && n < 3000) begin
            tick(1);
            n++;
        end
        chk("midreset reached", words.size() >= 40, 1);
        @(negedge i_clk);
        #3 i_reset = 1'b1;
        #1;
        chk_quiet("midreset");
        tick(2);
        chk_quiet("midreset_hold");
        rx_q.delete();
        i_reset = 1'b0;
        tick(2);
        run_dump(2'b01, 1, "after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
